// File: rtl/vc_inject_arb_pkg.sv
// Shared constants and types for the VC injection arbiter.
//   NUM_VC  : number of virtual channels feeding the arbiter
//   FLIT_W  : flit width; bits [34:33] carry the flit type, passed through untouched
//   LEN_W   : packet-length field width per VC
package vc_inject_arb_pkg;

  localparam int unsigned NUM_VC = 4;
  localparam int unsigned FLIT_W = 35;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned VC_W   = 2;

  typedef logic [VC_W-1:0] vc_t;

  typedef enum logic [1:0] {
    FT_HEAD      = 2'b00,
    FT_BODY      = 2'b01,
    FT_TAIL      = 2'b10,
    FT_HEAD_TAIL = 2'b11
  } flit_type_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/vc_inject_arb_if.sv
// Source-side / router-side bundle of the VC injection arbiter.
//   I_REQ    : per-VC packet pending
//   I_LEN    : per-VC packet length in flits (4 bits per VC)
//   I_DATA   : per-VC current flit (35 bits per VC)
//   I_CREDIT : per-VC downstream credit-return pulse
//   O_ACK    : combinational per-VC flit-consumed strobe
//   O_DATA   : registered flit toward the router
//   O_VALID  : registered qualifier of O_DATA
//   O_VCH    : registered VC number of O_DATA
// master = source/testbench side, slave = arbiter side.
interface vc_inject_arb_if;
  import vc_inject_arb_pkg::*;

  logic [NUM_VC-1:0]        I_REQ;
  logic [NUM_VC*LEN_W-1:0]  I_LEN;
  logic [NUM_VC*FLIT_W-1:0] I_DATA;
  logic [NUM_VC-1:0]        I_CREDIT;
  logic [NUM_VC-1:0]        O_ACK;
  logic [FLIT_W-1:0]        O_DATA;
  logic                     O_VALID;
  logic [VC_W-1:0]          O_VCH;

  modport master (
    output I_REQ, I_LEN, I_DATA, I_CREDIT,
    input  O_ACK, O_DATA, O_VALID, O_VCH
  );

  modport slave (
    input  I_REQ, I_LEN, I_DATA, I_CREDIT,
    output O_ACK, O_DATA, O_VALID, O_VCH
  );

endinterface

// File: rtl/vc_inject_arb_rr_arb4.sv
// Four-way round-robin selector (purely combinational).
//   elig       : eligible VC vector
//   last_grant : VC granted most recently; search starts one above it
//   grant      : selected VC (valid only when valid=1)
//   valid      : at least one VC eligible
module rr_arb4 (
  input  logic [3:0] elig,
  input  logic [1:0] last_grant,
  output logic [1:0] grant,
  output logic       valid
);

  logic [1:0] cand;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    cand  = '0;
    // Offsets 1..4 wrap mod 4, so last_grant itself is tried last.
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = last_grant + 2'(i);
      if (!valid && elig[cand]) begin
        grant = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_inject_arb.sv
// Credit-based wormhole injection arbiter for four virtual channels.
// In IDLE a round-robin grant is taken among VCs that have a packet
// pending and at least one downstream credit; in SEND the granted VC is
// locked until its whole packet has been forwarded, stalling whenever the
// source or the credits run dry.
//   CLK   : clock, rising edge
//   RST_N : synchronous active-low reset
//   bus   : source/router bundle (see vc_inject_arb_if)
// Parameters: CREDIT_MAX (downstream depth per VC, 1..7),
//             CRD_W (credit counter width, must hold CREDIT_MAX).
module vc_inject_arb
  import vc_inject_arb_pkg::*;
#(
  parameter int unsigned CREDIT_MAX = 4,
  parameter int unsigned CRD_W      = 3
) (
  input  logic           CLK,
  input  logic           RST_N,
  vc_inject_arb_if.slave bus
);

  state_t            state, state_nxt;
  logic [CRD_W-1:0]  credit [NUM_VC];
  vc_t               last_grant, g, rr_grant;
  logic              rr_valid;
  logic [LEN_W-1:0]  len, req_len, flit_cnt;
  logic [NUM_VC-1:0] elig, ack;
  logic [FLIT_W-1:0] g_data;
  logic              fire, last_flit;

  logic [FLIT_W-1:0] o_data_q;
  logic              o_valid_q;
  vc_t               o_vch_q;

  always_comb begin
    elig    = '0;
    g_data  = '0;
    req_len = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      elig[v] = bus.I_REQ[v] && (credit[v] != '0);
      if (vc_t'(v) == g)
        g_data = bus.I_DATA[v*FLIT_W +: FLIT_W];
      if (vc_t'(v) == rr_grant)
        req_len = bus.I_LEN[v*LEN_W +: LEN_W];
    end
  end

  rr_arb4 u_rr_arb4 (
    .elig       (elig),
    .last_grant (last_grant),
    .grant      (rr_grant),
    .valid      (rr_valid)
  );

  assign fire      = (state == SEND) && bus.I_REQ[g] && (credit[g] != '0);
  assign last_flit = (flit_cnt == len - LEN_W'(1));

  always_comb begin
    state_nxt = state;
    ack       = '0;
    unique case (state)
      IDLE: if (rr_valid) state_nxt = SEND;
      SEND: begin
        if (fire) begin
          ack[g] = 1'b1;
          if (last_flit) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Reset must not let the source advance, so the strobe is gated here.
    if (!RST_N) ack = '0;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      last_grant <= vc_t'(NUM_VC - 1);
      g          <= '0;
      len        <= '0;
      flit_cnt   <= '0;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      o_vch_q    <= '0;
    end else begin
      if (state == IDLE && rr_valid) begin
        g        <= rr_grant;
        len      <= (req_len == '0) ? LEN_W'(1) : req_len;
        flit_cnt <= '0;
      end
      if (fire) begin
        flit_cnt <= flit_cnt + LEN_W'(1);
        o_data_q <= g_data;
        o_vch_q  <= g;
        if (last_flit) last_grant <= g;
      end
      o_valid_q <= fire;
    end
  end

  // ack doubles as the per-VC consume vector: a simultaneous consume and
  // return cancel; returns at CREDIT_MAX are dropped.
  always_ff @(posedge CLK) begin
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (!RST_N)
        credit[v] <= CRD_W'(CREDIT_MAX);
      else if (ack[v] && !bus.I_CREDIT[v])
        credit[v] <= credit[v] - CRD_W'(1);
      else if (bus.I_CREDIT[v] && !ack[v] && credit[v] != CRD_W'(CREDIT_MAX))
        credit[v] <= credit[v] + CRD_W'(1);
    end
  end

  assign bus.O_ACK   = ack;
  assign bus.O_DATA  = o_data_q;
  assign bus.O_VALID = o_valid_q;
  assign bus.O_VCH   = o_vch_q;

endmodule

// File: tb/tb_vc_inject_arb.sv
// Scoreboard bench for vc_inject_arb: directed packet scenarios push the
// hand-derived flit sequence into a queue; a negedge monitor pops and
// compares every O_VALID beat and records its cycle for timing checks.
module tb_vc_inject_arb;
  import vc_inject_arb_pkg::*;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic src_clr = 1'b1;

  vc_inject_arb_if bus ();

  vc_inject_arb #(.CREDIT_MAX(4), .CRD_W(3)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]  vch;
    logic [34:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   beat_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   beats  = 0;

  // Source model: per VC a packet budget, a length and a hold mask.
  int         pkts_req [4];
  logic [3:0] src_len  [4];
  logic [3:0] hold;
  int         idx  [4];
  int         done [4];

  function automatic logic [3:0] eff_len(input logic [3:0] l);
    return (l == 4'd0) ? 4'd1 : l;
  endfunction

  function automatic logic [34:0] mkflit(input int v, input int p, input int n, input logic [3:0] l);
    logic [3:0] e;
    logic [1:0] t;
    e = eff_len(l);
    if (n == 0 && e == 4'd1) t = 2'b11;
    else if (n == 0)         t = 2'b00;
    else if (n == int'(e) - 1) t = 2'b10;
    else                     t = 2'b01;
    return {t, 9'h0A5, 4'(v), 8'(p), 12'(n)};
  endfunction

  logic [3:0]   drv_req;
  logic [15:0]  drv_len;
  logic [139:0] drv_data;

  always_comb begin
    drv_req  = '0;
    drv_len  = '0;
    drv_data = '0;
    for (int v = 0; v < 4; v++) begin
      drv_req[v]             = (done[v] < pkts_req[v]) && !hold[v];
      drv_len[v*4 +: 4]      = src_len[v];
      drv_data[v*35 +: 35]   = mkflit(v, done[v], idx[v], src_len[v]);
    end
  end

  assign bus.I_REQ  = drv_req;
  assign bus.I_LEN  = drv_len;
  assign bus.I_DATA = drv_data;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    for (int v = 0; v < 4; v++) begin
      if (src_clr) begin
        idx[v]  <= 0;
        done[v] <= 0;
      end else if (bus.O_ACK[v]) begin
        if (idx[v] == int'(eff_len(src_len[v])) - 1) begin
          idx[v]  <= 0;
          done[v] <= done[v] + 1;
        end else begin
          idx[v] <= idx[v] + 1;
        end
      end
    end
  end

  // Monitor
  always @(negedge CLK) begin
    checks++;
    if (!$onehot0(bus.O_ACK)) begin
      errors++;
      $display("FAIL ack_onehot: O_ACK=%b, required one-hot or zero", bus.O_ACK);
    end
    if (bus.O_VALID === 1'b1) begin
      beat_cyc.push_back(cyc);
      beats++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_flit: got vch=%0d data=%h, required no flit", bus.O_VCH, bus.O_DATA);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.O_VCH !== e.vch || bus.O_DATA !== e.data) begin
          errors++;
          $display("FAIL flit_data: got vch=%0d data=%h, required vch=%0d data=%h",
                   bus.O_VCH, bus.O_DATA, e.vch, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int beat_at(input int i);
    if (i < beat_cyc.size()) return beat_cyc[i];
    return -1000;
  endfunction

  task automatic push_pkt(input int v, input int p, input int first, input int nflits, input logic [3:0] l);
    exp_t e;
    for (int n = first; n < first + nflits; n++) begin
      e.vch  = 2'(v);
      e.data = mkflit(v, p, n, l);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    src_clr = 1'b1;
    hold = '0;
    bus.I_CREDIT = '0;
    for (int v = 0; v < 4; v++) begin
      pkts_req[v] = 0;
      src_len[v]  = '0;
    end
    tick();
    tick();
    RST_N = 1'b1;
    src_clr = 1'b0;
    tick();
    chk("leftover_expected", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (beats < n && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (beats < n) begin
      errors++;
      $display("FAIL %s: got %0d beats, required %0d within %0d cycles", name, beats, n, budget);
    end
  endtask

  task automatic credit_pulse(input logic [3:0] m);
    bus.I_CREDIT = m;
    tick();
    bus.I_CREDIT = '0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b0, b1, c0;
    hold = '0;
    bus.I_CREDIT = '0;
    for (int v = 0; v < 4; v++) begin
      pkts_req[v] = 0;
      src_len[v]  = '0;
    end

    // Reset values
    do_reset();
    chk("rst_o_valid", bus.O_VALID, 0);
    chk("rst_o_data", bus.O_DATA, 0);
    chk("rst_o_vch", bus.O_VCH, 0);
    chk("rst_o_ack", bus.O_ACK, 0);

    // Single VC0 packet of 3, then credit[0] must be 1
    b0 = beats;
    src_len[0] = 4'd3;
    push_pkt(0, 0, 0, 3, 4'd3);
    pkts_req[0] = 1;
    c0 = cyc;
    wait_beats(b0 + 3, 20, "t1_beats");
    chk("t1_first_latency", beat_at(b0) - c0, 2);
    chk("t1_burst_span", beat_at(b0 + 2) - beat_at(b0), 2);
    push_pkt(0, 1, 0, 1, 4'd3);
    pkts_req[0] = 2;
    repeat (12) tick();
    chk("t1_credit_left_one", beats - b0, 4);

    // All VCs, len 1: order 0,1,2,3,0 with one bubble between packets
    do_reset();
    b0 = beats;
    for (int v = 0; v < 4; v++) src_len[v] = 4'd1;
    push_pkt(0, 0, 0, 1, 4'd1);
    push_pkt(1, 0, 0, 1, 4'd1);
    push_pkt(2, 0, 0, 1, 4'd1);
    push_pkt(3, 0, 0, 1, 4'd1);
    push_pkt(0, 1, 0, 1, 4'd1);
    pkts_req[0] = 2;
    pkts_req[1] = 1;
    pkts_req[2] = 1;
    pkts_req[3] = 1;
    wait_beats(b0 + 5, 40, "t2_beats");
    for (int k = 1; k <= 4; k++)
      chk($sformatf("t2_gap%0d", k), beat_at(b0 + k) - beat_at(b0 + k - 1), 2);

    // VC2 len 6 with 4 credits: stall, grant held, then resume on returns
    do_reset();
    b0 = beats;
    src_len[2] = 4'd6;
    push_pkt(2, 0, 0, 6, 4'd6);
    pkts_req[2] = 1;
    wait_beats(b0 + 4, 20, "t3_first4");
    repeat (6) tick();
    chk("t3_stall_beats", beats - b0, 4);
    chk("t3_stall_valid", bus.O_VALID, 0);
    src_len[1] = 4'd1;
    push_pkt(1, 0, 0, 1, 4'd1);
    pkts_req[1] = 1;
    repeat (4) tick();
    chk("t3_grant_held", beats - b0, 4);
    credit_pulse(4'b0100);
    credit_pulse(4'b0100);
    wait_beats(b0 + 7, 20, "t3_resume");

    // Credit return on the same cycle as a VC1 fire leaves credit unchanged
    do_reset();
    b0 = beats;
    src_len[1] = 4'd4;
    push_pkt(1, 0, 0, 4, 4'd4);
    pkts_req[1] = 1;
    tick();
    bus.I_CREDIT = 4'b0010;
    tick();
    bus.I_CREDIT = '0;
    wait_beats(b0 + 4, 20, "t4_pkt");
    push_pkt(1, 1, 0, 1, 4'd4);
    pkts_req[1] = 2;
    repeat (12) tick();
    chk("t4_same_cycle_credit", beats - b0, 5);

    // Returns at full credit saturate at 4
    do_reset();
    b0 = beats;
    credit_pulse(4'b0010);
    credit_pulse(4'b0010);
    credit_pulse(4'b0010);
    src_len[1] = 4'd6;
    push_pkt(1, 0, 0, 4, 4'd6);
    pkts_req[1] = 1;
    wait_beats(b0 + 4, 20, "t4_sat_pkt");
    repeat (8) tick();
    chk("t4_saturate", beats - b0, 4);

    // Reset during flit 2 of a VC1 len-5 packet
    do_reset();
    b0 = beats;
    src_len[2] = 4'd1;
    push_pkt(2, 0, 0, 1, 4'd1);
    pkts_req[2] = 1;
    wait_beats(b0 + 1, 20, "t5_pre");
    repeat (2) tick();
    b1 = beats;
    src_len[1] = 4'd5;
    push_pkt(1, 0, 0, 2, 4'd5);
    pkts_req[1] = 1;
    tick();
    tick();
    tick();
    RST_N = 1'b0;
    src_clr = 1'b1;
    pkts_req[2] = 0;
    #3;
    chk("t5_ack_in_reset", bus.O_ACK, 0);
    tick();
    RST_N = 1'b1;
    src_clr = 1'b0;
    chk("t5_valid_after_reset", bus.O_VALID, 0);
    chk("t5_flits_before_reset", beats - b1, 2);
    src_len[1] = 4'd4;
    src_len[2] = 4'd4;
    src_len[3] = 4'd1;
    push_pkt(1, 0, 0, 4, 4'd4);
    push_pkt(2, 0, 0, 4, 4'd4);
    push_pkt(3, 0, 0, 1, 4'd1);
    pkts_req[2] = 1;
    pkts_req[3] = 1;
    wait_beats(b1 + 11, 60, "t5_after_reset");

    // VC0 request dropped two cycles mid-packet; VC3 waits
    do_reset();
    b0 = beats;
    src_len[0] = 4'd4;
    src_len[3] = 4'd1;
    push_pkt(0, 0, 0, 4, 4'd4);
    push_pkt(3, 0, 0, 1, 4'd1);
    pkts_req[0] = 1;
    pkts_req[3] = 1;
    tick();
    tick();
    hold = 4'b0001;
    tick();
    tick();
    hold = 4'b0000;
    wait_beats(b0 + 5, 30, "t6_beats");
    chk("t6_gap", beat_at(b0 + 1) - beat_at(b0), 3);
    chk("t6_span", beat_at(b0 + 3) - beat_at(b0), 5);
    chk("t6_next_pkt_gap", beat_at(b0 + 4) - beat_at(b0 + 3), 2);

    // len 0 behaves as a single-flit packet
    do_reset();
    b0 = beats;
    src_len[2] = 4'd0;
    push_pkt(2, 0, 0, 1, 4'd0);
    push_pkt(2, 1, 0, 1, 4'd0);
    pkts_req[2] = 2;
    wait_beats(b0 + 2, 20, "t7_beats");
    repeat (4) tick();
    chk("t7_len0_gap", beat_at(b0 + 1) - beat_at(b0), 2);
    chk("t7_len0_count", beats - b0, 2);

    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
